// File: rtl/ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// ahb_apb_bridge
//   AHB-Lite slave to APB master bridge. Each AHB NONSEQ/SEQ beat becomes one
//   APB SETUP + ACCESS transfer to one of two APB slaves (Haddr[31] selects).
//   A Moore FSM drives the APB side. `ready` (HREADYOUT) stalls the AHB master
//   while a read is in SETUP, or while a pipelined write is pending.
//
// Ports
//   Hclk, Hresetn         clock, asynchronous active-low reset
//   Haddr, Hwrite, Htrans AHB address phase (Hburst, Hsize are ignored)
//   Hwdata                AHB write data, one cycle after its address phase
//   Hrdata                AHB read data (pass-through of Prdata)
//   ready                 HREADYOUT to the AHB master
//   Paddr, Pwrite, Psel,  APB master outputs
//   Penable, Pwdata
//   Prdata                APB read data
// -----------------------------------------------------------------------------
module ahb_apb_bridge (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        Hwrite,
  input  logic [2:0]  Hburst,
  input  logic [1:0]  Htrans,
  input  logic [1:0]  Hsize,
  input  logic [31:0] Prdata,
  output logic [31:0] Paddr,
  output logic        Pwrite,
  output logic [1:0]  Psel,
  output logic        Penable,
  output logic [31:0] Pwdata,
  output logic        ready,
  output logic [31:0] Hrdata
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t      PS;
  state_t      w_ns;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] addr2;
  logic [31:0] addr3;
  logic        r_hwrite;
  logic [31:0] r_pwdata;
  logic        w_pend;
  logic [31:0] w_sel_addr;
  logic        w_unused;

  // Burst type, size, the BUSY/SEQ distinction and the delayed address copy
  // carry no function in this bridge.
  assign w_unused = ^{Hburst, Hsize, Htrans[0], addr2};

  assign valid  = Htrans[1];
  assign Hrdata = Prdata;
  assign Pwdata = r_pwdata;

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_ns = PS;
    case (PS)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (valid && Hwrite)      w_ns = ST_WWAIT;
        else if (valid)           w_ns = ST_READ;
        else                      w_ns = ST_IDLE;
      end
      ST_WWAIT:    w_ns = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     w_ns = ST_RENABLE;
      ST_WRITE:    w_ns = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   w_ns = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!r_hwrite)            w_ns = ST_READ;
        else if (valid)           w_ns = ST_WRITEP;
        else                      w_ns = ST_WRITE;
      end
      default:     w_ns = ST_IDLE;
    endcase
  end

  // Moore output decode. While a pipelined write is on the bus, addr already
  // holds the next beat, so the APB address comes from addr3.
  always_comb begin
    w_pend     = (PS == ST_WRITEP) || (PS == ST_WENABLEP);
    w_sel_addr = w_pend ? addr3 : addr;
    Paddr      = w_sel_addr;
    Psel       = 2'b00;
    Penable    = 1'b0;
    Pwrite     = 1'b0;
    ready      = 1'b1;
    case (PS)
      ST_READ:     begin Psel = w_sel_addr[31] ? 2'b10 : 2'b01; ready = 1'b0; end
      ST_RENABLE:  begin Psel = w_sel_addr[31] ? 2'b10 : 2'b01; Penable = 1'b1; end
      ST_WRITE:    begin Psel = w_sel_addr[31] ? 2'b10 : 2'b01; Pwrite = 1'b1; end
      ST_WRITEP:   begin
        Psel   = w_sel_addr[31] ? 2'b10 : 2'b01;
        Pwrite = 1'b1;
        ready  = 1'b0;
      end
      ST_WENABLE, ST_WENABLEP: begin
        Psel    = w_sel_addr[31] ? 2'b10 : 2'b01;
        Penable = 1'b1;
        Pwrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others (addr3 <= addr relies
  // on this to capture the old address while addr loads the new one).
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      PS       <= ST_IDLE;
      addr     <= '0;
      addr2    <= '0;
      addr3    <= '0;
      r_hwrite <= 1'b0;
      r_pwdata <= '0;
    end else begin
      PS    <= w_ns;
      addr2 <= addr;
      if (valid && ready) begin
        addr     <= Haddr;
        r_hwrite <= Hwrite;
      end
      // addr3 holds the write currently on APB while addr tracks the next
      // beat; WRITE -> WENABLEP also leaves addr pointing past the bus beat.
      if ((w_ns == ST_WRITEP && PS != ST_WRITEP) ||
          (PS == ST_WRITE && w_ns == ST_WENABLEP))
        addr3 <= addr;
      // Write data is captured when its data phase completes: in WWAIT for
      // the first beat, and in WENABLEP for a pipelined beat, whose Hwdata is
      // held through the WRITEP stall. Loading earlier would overwrite the
      // data of the write still in its ACCESS phase.
      if (PS == ST_WWAIT || (PS == ST_WENABLEP && r_hwrite))
        r_pwdata <= Hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_ahb_apb_bridge
//   Directed bench for ahb_apb_bridge. A vector table walks the bridge through
//   IDLE/BUSY, a single write, a single read, back-to-back writes and a
//   write followed by a read, one row per clock. Observed APB accesses are
//   logged and compared against the expected order. A hand sequence then
//   asserts reset asynchronously in the middle of a WENABLE.
// -----------------------------------------------------------------------------
module tb_ahb_apb_bridge;

  localparam logic [2:0] S_IDLE = 3'd0, S_WWAIT = 3'd1, S_READ = 3'd2,
                         S_WRITE = 3'd3, S_WRITEP = 3'd4, S_RENABLE = 3'd5,
                         S_WENABLE = 3'd6, S_WENABLEP = 3'd7;

  logic        Hclk;
  logic        Hresetn;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hwrite;
  logic [2:0]  Hburst;
  logic [1:0]  Htrans;
  logic [1:0]  Hsize;
  logic [31:0] Prdata;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic [1:0]  Psel;
  logic        Penable;
  logic [31:0] Pwdata;
  logic        ready;
  logic [31:0] Hrdata;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_apb_bridge dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .Haddr   (Haddr),
    .Hwdata  (Hwdata),
    .Hwrite  (Hwrite),
    .Hburst  (Hburst),
    .Htrans  (Htrans),
    .Hsize   (Hsize),
    .Prdata  (Prdata),
    .Paddr   (Paddr),
    .Pwrite  (Pwrite),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwdata  (Pwdata),
    .ready   (ready),
    .Hrdata  (Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic [2:0]  ps;
    logic [1:0]  psel;
    logic        pen;
    logic        pwr;
    logic        rdy;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_t;

  vec_t vecs[27];
  apb_t seen[$];
  apb_t want[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d,
    input logic [31:0] pr, input logic [2:0] ps, input logic [1:0] sel,
    input logic en, input logic pw, input logic rd,
    input logic [31:0] pa, input logic [31:0] pd);
    vec_t v;
    v.htrans = t;  v.haddr = a;  v.hwrite = w;  v.hwdata = d;  v.prdata = pr;
    v.ps = ps;     v.psel = sel; v.pen = en;    v.pwr = pw;    v.rdy = rd;
    v.paddr = pa;  v.pwdata = pd;
    return v;
  endfunction

  function automatic apb_t acc(input logic wr, input logic [31:0] a, input logic [31:0] d);
    apb_t x;
    x.wr = wr; x.addr = a; x.data = d;
    return x;
  endfunction

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [31:0] pr);
    Htrans = t; Haddr = a; Hwrite = w; Hwdata = d; Prdata = pr;
  endtask

  initial begin
    logic [2:0] ps_v;
    // Inputs: htrans, haddr, hwrite, hwdata, prdata
    // Expect: PS, Psel, Penable, Pwrite, ready, Paddr, Pwdata
    // IDLE and BUSY never start a transfer
    vecs[0]  = mk(2'b00, 32'h20, 1'b0, 32'hAA, 32'h1234_5678, S_IDLE, 2'b00, 0, 0, 1, 32'h0, 32'h0);
    vecs[1]  = mk(2'b00, 32'h20, 1'b1, 32'hBB, 32'h1234_5678, S_IDLE, 2'b00, 0, 0, 1, 32'h0, 32'h0);
    vecs[2]  = mk(2'b01, 32'h20, 1'b0, 32'hAA, 32'h1234_5678, S_IDLE, 2'b00, 0, 0, 1, 32'h0, 32'h0);
    vecs[3]  = mk(2'b01, 32'h20, 1'b1, 32'hBB, 32'h1234_5678, S_IDLE, 2'b00, 0, 0, 1, 32'h0, 32'h0);
    // Single write 0x20 <- 0xAA
    vecs[4]  = mk(2'b10, 32'h20, 1'b1, 32'h0,  32'h1234_5678, S_IDLE,     2'b00, 0, 0, 1, 32'h0,  32'h0);
    vecs[5]  = mk(2'b00, 32'h0,  1'b0, 32'hAA, 32'h1234_5678, S_WWAIT,    2'b00, 0, 0, 1, 32'h20, 32'h0);
    vecs[6]  = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_WRITE,    2'b01, 0, 1, 1, 32'h20, 32'hAA);
    vecs[7]  = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_WENABLE,  2'b01, 1, 1, 1, 32'h20, 32'hAA);
    vecs[8]  = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_IDLE,     2'b00, 0, 0, 1, 32'h20, 32'hAA);
    // Single read from slave 2
    vecs[9]  = mk(2'b10, 32'h8000_0010, 1'b0, 32'h0, 32'h1234_5678, S_IDLE, 2'b00, 0, 0, 1, 32'h20, 32'hAA);
    vecs[10] = mk(2'b00, 32'h0, 1'b0, 32'h0, 32'h1234_5678, S_READ,    2'b10, 0, 0, 0, 32'h8000_0010, 32'hAA);
    vecs[11] = mk(2'b00, 32'h0, 1'b0, 32'h0, 32'h1234_5678, S_RENABLE, 2'b10, 1, 0, 1, 32'h8000_0010, 32'hAA);
    vecs[12] = mk(2'b00, 32'h0, 1'b0, 32'h0, 32'h1234_5678, S_IDLE,    2'b00, 0, 0, 1, 32'h8000_0010, 32'hAA);
    // Back-to-back writes 0x20 <- 0xAA, 0x24 <- 0xBB
    vecs[13] = mk(2'b10, 32'h20, 1'b1, 32'h0,  32'h1234_5678, S_IDLE,     2'b00, 0, 0, 1, 32'h8000_0010, 32'hAA);
    vecs[14] = mk(2'b10, 32'h24, 1'b1, 32'hAA, 32'h1234_5678, S_WWAIT,    2'b00, 0, 0, 1, 32'h20, 32'hAA);
    vecs[15] = mk(2'b00, 32'h0,  1'b0, 32'hBB, 32'h1234_5678, S_WRITEP,   2'b01, 0, 1, 0, 32'h20, 32'hAA);
    vecs[16] = mk(2'b00, 32'h0,  1'b0, 32'hBB, 32'h1234_5678, S_WENABLEP, 2'b01, 1, 1, 1, 32'h20, 32'hAA);
    vecs[17] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_WRITE,    2'b01, 0, 1, 1, 32'h24, 32'hBB);
    vecs[18] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_WENABLE,  2'b01, 1, 1, 1, 32'h24, 32'hBB);
    vecs[19] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h1234_5678, S_IDLE,     2'b00, 0, 0, 1, 32'h24, 32'hBB);
    // Write 0x28 <- 0xCC immediately followed by read of 0x30
    vecs[20] = mk(2'b10, 32'h28, 1'b1, 32'h0,  32'h0BAD_F00D, S_IDLE,     2'b00, 0, 0, 1, 32'h24, 32'hBB);
    vecs[21] = mk(2'b10, 32'h30, 1'b0, 32'hCC, 32'h0BAD_F00D, S_WWAIT,    2'b00, 0, 0, 1, 32'h28, 32'hBB);
    vecs[22] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h0BAD_F00D, S_WRITEP,   2'b01, 0, 1, 0, 32'h28, 32'hCC);
    vecs[23] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h0BAD_F00D, S_WENABLEP, 2'b01, 1, 1, 1, 32'h28, 32'hCC);
    vecs[24] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h0BAD_F00D, S_READ,     2'b01, 0, 0, 0, 32'h30, 32'hCC);
    vecs[25] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h0BAD_F00D, S_RENABLE,  2'b01, 1, 0, 1, 32'h30, 32'hCC);
    vecs[26] = mk(2'b00, 32'h0,  1'b0, 32'h0,  32'h0BAD_F00D, S_IDLE,     2'b00, 0, 0, 1, 32'h30, 32'hCC);

    want.push_back(acc(1'b1, 32'h20, 32'hAA));
    want.push_back(acc(1'b0, 32'h8000_0010, 32'h0));
    want.push_back(acc(1'b1, 32'h20, 32'hAA));
    want.push_back(acc(1'b1, 32'h24, 32'hBB));
    want.push_back(acc(1'b1, 32'h28, 32'hCC));
    want.push_back(acc(1'b0, 32'h30, 32'h0));

    // Reset state
    Hresetn = 1'b0;
    Hburst  = 3'b001;
    Hsize   = 2'b10;
    drive(2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
    #3;
    ps_v = dut.PS;
    check("reset PS", 32'(ps_v), 32'(S_IDLE));
    check("reset Psel", 32'(Psel), 32'h0);
    check("reset Penable", 32'(Penable), 32'h0);
    check("reset Pwrite", 32'(Pwrite), 32'h0);
    check("reset ready", 32'(ready), 32'h1);
    check("reset Paddr", Paddr, 32'h0);
    check("reset Pwdata", Pwdata, 32'h0);
    #9 Hresetn = 1'b1;

    // Table: drive just after the rising edge, compare at the falling edge
    for (int i = 0; i < 27; i++) begin
      @(posedge Hclk);
      #1;
      drive(vecs[i].htrans, vecs[i].haddr, vecs[i].hwrite, vecs[i].hwdata, vecs[i].prdata);
      @(negedge Hclk);
      ps_v = dut.PS;
      check($sformatf("v%0d PS", i),      32'(ps_v),    32'(vecs[i].ps));
      check($sformatf("v%0d Psel", i),    32'(Psel),    32'(vecs[i].psel));
      check($sformatf("v%0d Penable", i), 32'(Penable), 32'(vecs[i].pen));
      check($sformatf("v%0d Pwrite", i),  32'(Pwrite),  32'(vecs[i].pwr));
      check($sformatf("v%0d ready", i),   32'(ready),   32'(vecs[i].rdy));
      check($sformatf("v%0d Paddr", i),   Paddr,        vecs[i].paddr);
      check($sformatf("v%0d Pwdata", i),  Pwdata,       vecs[i].pwdata);
      check($sformatf("v%0d Hrdata", i),  Hrdata,       vecs[i].prdata);
      if (Penable)
        seen.push_back(acc(Pwrite, Paddr, Pwrite ? Pwdata : 32'h0));
    end

    // APB access order and address/data pairing
    check("apb access count", 32'(seen.size()), 32'(want.size()));
    for (int k = 0; k < want.size() && k < seen.size(); k++) begin
      check($sformatf("apb%0d dir", k),  32'(seen[k].wr), 32'(want[k].wr));
      check($sformatf("apb%0d addr", k), seen[k].addr,    want[k].addr);
      check($sformatf("apb%0d data", k), seen[k].data,    want[k].data);
    end

    // Asynchronous reset in the middle of WENABLE
    @(posedge Hclk); #1 drive(2'b10, 32'h8000_0040, 1'b1, 32'h0, 32'h0);
    @(posedge Hclk); #1 drive(2'b00, 32'h0, 1'b0, 32'h55, 32'h0);
    @(posedge Hclk); #1 drive(2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge Hclk); #1;
    ps_v = dut.PS;
    check("pre-abort PS", 32'(ps_v), 32'(S_WENABLE));
    check("pre-abort Psel", 32'(Psel), 32'h2);
    check("pre-abort Penable", 32'(Penable), 32'h1);
    check("pre-abort Pwdata", Pwdata, 32'h55);
    #2 Hresetn = 1'b0;
    #1;
    ps_v = dut.PS;
    check("abort PS", 32'(ps_v), 32'(S_IDLE));
    check("abort Psel", 32'(Psel), 32'h0);
    check("abort Penable", 32'(Penable), 32'h0);
    check("abort Pwrite", 32'(Pwrite), 32'h0);
    check("abort ready", 32'(ready), 32'h1);
    check("abort Paddr", Paddr, 32'h0);
    check("abort Pwdata", Pwdata, 32'h0);
    @(negedge Hclk) Hresetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge Hclk);
      ps_v = dut.PS;
      check($sformatf("post-abort%0d PS", c), 32'(ps_v), 32'(S_IDLE));
      check($sformatf("post-abort%0d Penable", c), 32'(Penable), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
